// File: rtl/mult_dot_seq.sv
// Multi-word packed dot-product sequencer: streams operand pairs through the
// multiplier's dot path, chaining each partial sum back as the accumulator.
module mult_dot_seq #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             mode_i,
  input  logic [1:0]       signed_i,
  input  logic [31:0]      acc_init_i,
  input  logic             abort_i,
  output logic             busy_o,
  input  logic             opnd_valid_i,
  output logic             opnd_ready_o,
  input  logic [31:0]      opnd_a_i,
  input  logic [31:0]      opnd_b_i,
  output logic             mult_enable_o,
  output logic [2:0]       mult_operator_o,
  output logic [1:0]       mult_dot_signed_o,
  output logic [31:0]      mult_dot_op_a_o,
  output logic [31:0]      mult_dot_op_b_o,
  output logic [31:0]      mult_dot_op_c_o,
  input  logic [31:0]      mult_result_i,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [31:0]      done_result_o,
  output logic [LEN_W-1:0] done_count_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] MUL_DOT8  = 3'b100;
  localparam logic [2:0] MUL_DOT16 = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [1:0]       sgn_q, sgn_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      sgn_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      sgn_q   <= sgn_d;
    end
  end

  // Next-state and handshake logic; abort only matters while a job is streaming.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    mode_d        = mode_q;
    sgn_d         = sgn_q;
    opnd_ready_o  = 1'b0;
    mult_enable_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d = acc_init_i;
          cnt_d = '0;
          if (len_i != '0) begin
            len_d   = len_i;
            mode_d  = mode_i;
            sgn_d   = signed_i;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        opnd_ready_o  = ~abort_i;
        mult_enable_o = opnd_valid_i & ~abort_i;
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (opnd_valid_i) begin
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = mult_result_i;
          state_d = (cnt_q == len_q) ? ST_DONE : ST_FETCH;
        end
      end
      default: begin
        if (done_ready_i) state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o            = (state_q != ST_IDLE);
  assign done_valid_o      = (state_q == ST_DONE);
  assign done_result_o     = acc_q;
  assign done_count_o      = cnt_q;
  assign mult_operator_o   = mode_q ? MUL_DOT16 : MUL_DOT8;
  assign mult_dot_signed_o = sgn_q;
  assign mult_dot_op_a_o   = opnd_a_i;
  assign mult_dot_op_b_o   = opnd_b_i;
  assign mult_dot_op_c_o   = acc_q;

endmodule
